// File: rtl/booth_multiplier.sv
// Sequential 8x8 signed multiplier using radix-2 Booth recoding.
// It performs one add/subtract-and-shift step per clock and completes in 8 steps.
module booth_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [8:0]  m_reg;
  logic [8:0]  acc_reg;
  logic [7:0]  q_reg;
  logic        q1_reg;
  logic [15:0] product_reg;

  logic        load;
  logic        step;
  logic        last;
  logic [8:0]  sum;
  logic [8:0]  acc_next;
  logic [7:0]  q_next;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = start ? CALC : IDLE;
      CALC:       state_next = (cnt_reg == 3'd7) ? DONE : CALC;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    load = (state_reg != CALC) && start;
    step = (state_reg == CALC);
    last = step && (cnt_reg == 3'd7);
  end

  // The 9-bit accumulator keeps acc - M exact even when M = -128.
  always_comb begin
    case ({q_reg[0], q1_reg})
      2'b01:   sum = acc_reg + m_reg;
      2'b10:   sum = acc_reg + ~m_reg + 9'd1;
      default: sum = acc_reg;
    endcase
    acc_next = {sum[8], sum[8:1]};
    q_next   = {sum[0], q_reg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      q1_reg      <= 1'b0;
      product_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
      m_reg   <= {a[7], a};
      acc_reg <= '0;
      q_reg   <= b;
      q1_reg  <= 1'b0;
    end else if (step) begin
      cnt_reg <= cnt_reg + 3'd1;
      acc_reg <= acc_next;
      q_reg   <= q_next;
      q1_reg  <= q_reg[0];
      if (last) product_reg <= {acc_next[7:0], q_next};
    end
  end

  assign busy    = (state_reg == CALC);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corner cases, random
// operand pairs against an integer-multiply reference, and control scenarios.
module tb_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  booth_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to completion; inputs change on negedges.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] prev;
    int lat;
    prev = product;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
      check("product_held", product, prev);
    end
    check("latency", lat, 8);
    check("product", product, ref_mul(x, y));
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    $display("op a=%0d b=%0d product=%0h expected=%0h latency=%0d",
             $signed(x), $signed(y), product, ref_mul(x, y), lat);
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;
    logic [15:0] got;
    logic [7:0] dir_a [6];
    logic [7:0] dir_b [6];
    dir_a = '{8'd50, 8'hFF, 8'h80, 8'h80, 8'd1,  8'd0};
    dir_b = '{8'd70, 8'd127, 8'h80, 8'd1, 8'h80, 8'hFF};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);

    // Idle stability
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_product", product, 0);
    end

    for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i]);
    for (int i = 0; i < 30; i++) run_op(8'($urandom), 8'($urandom));

    // Start while busy: a second start at E3 must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd5;
    @(negedge clk);
    start = 1'b0;
    dones = 0; first_done = 0; got = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'd7; b = 8'd9; end
      else start = 1'b0;
      @(negedge clk);
      if (done) begin dones++; first_done = i; got = product; end
    end
    start = 1'b0;
    check("busy_ignore_dones", dones, 1);
    check("busy_ignore_edge", first_done, 8);
    check("busy_ignore_product", got, 16'h000F);
    $display("start-while-busy: dones=%0d edge=%0d product=%0h", dones, first_done, got);

    // Back-to-back with start held
    @(negedge clk);
    start = 1'b1; a = 8'd2; b = 8'd3;
    @(negedge clk);
    a = $urandom; b = $urandom;
    dones = 0; first_done = 0; second_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_done = i;
          check("b2b_first_product", product, 16'd6);
          a = 8'hFC; b = 8'd6;
        end else begin
          second_done = i;
          check("b2b_second_product", product, ref_mul(8'hFC, 8'd6));
          start = 1'b0;
        end
      end else if (dones == 1 && i < 17) begin
        check("b2b_hold_product", product, 16'd6);
        check("b2b_busy", busy, 1);
        a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    check("b2b_first_edge", first_done, 8);
    check("b2b_second_edge", second_done, 17);
    check("b2b_dones", dones, 2);
    $display("back-to-back: done edges %0d and %0d, product=%0h", first_done, second_done, product);

    // Reset mid-operation at E4
    @(negedge clk);
    start = 1'b1; a = 8'd10; b = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_product", product, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_mid_no_done", dones, 0);
    $display("reset mid-op: busy=%0b product=%0h later dones=%0d", busy, product, dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
